// File: rtl/delay_mux_filter.sv
// Debounces the asynchronous delay-mux output: 2-flop sync, stability FSM, edge strobes, counter, event port.
// Optional macro DELAY_MUX_GLITCH_CNT_EN adds a saturating count of rejected pulses (glitch_cnt).
module delay_mux_filter #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             y_in,
  output logic             y_filt,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             evt_valid,
  output logic             evt_rise,
  input  logic             evt_ready,
  output logic             evt_ovf
`ifdef DELAY_MUX_GLITCH_CNT_EN
  ,
  output logic [CNT_W-1:0] glitch_cnt
`endif
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam logic [SW-1:0] SC_LAST = SW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {ST_LO, CHK_HI, ST_HI, CHK_LO} state_t;

  logic          s1, s2;
  state_t        state, state_nxt;
  logic [SW-1:0] scnt, scnt_nxt;
  logic          rise_nxt, fall_nxt;
  logic          hs, strobe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= y_in;
      s2 <= s1;
    end
  end

  always_comb begin
    state_nxt = state;
    scnt_nxt  = scnt;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      ST_LO: if (s2) begin
        state_nxt = CHK_HI;
        scnt_nxt  = SW'(1);
      end
      CHK_HI: begin
        if (!s2) begin
          state_nxt = ST_LO;
          scnt_nxt  = '0;
        end else if (scnt == SC_LAST) begin
          state_nxt = ST_HI;
          scnt_nxt  = '0;
          rise_nxt  = 1'b1;
        end else begin
          scnt_nxt = scnt + 1'b1;
        end
      end
      ST_HI: if (!s2) begin
        state_nxt = CHK_LO;
        scnt_nxt  = SW'(1);
      end
      CHK_LO: begin
        if (s2) begin
          state_nxt = ST_HI;
          scnt_nxt  = '0;
        end else if (scnt == SC_LAST) begin
          state_nxt = ST_LO;
          scnt_nxt  = '0;
          fall_nxt  = 1'b1;
        end else begin
          scnt_nxt = scnt + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_LO;
        scnt_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_LO;
      scnt   <= '0;
      y_filt <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      state <= state_nxt;
      scnt  <= scnt_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
      if (rise_nxt)      y_filt <= 1'b1;
      else if (fall_nxt) y_filt <= 1'b0;
    end
  end

  // Counter and event port react to the registered strobes, one cycle after y_filt moves.
  assign hs     = evt_valid & evt_ready;
  assign strobe = rise | fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt  <= '0;
      evt_valid <= 1'b0;
      evt_rise  <= 1'b0;
      evt_ovf   <= 1'b0;
    end else begin
      if (strobe && edge_cnt != {CNT_W{1'b1}})
        edge_cnt <= edge_cnt + 1'b1;
      if (strobe) begin
        if (!evt_valid || hs) begin
          evt_valid <= 1'b1;
          evt_rise  <= rise;
        end else begin
          evt_ovf <= 1'b1;
        end
      end else if (hs) begin
        evt_valid <= 1'b0;
      end
    end
  end

`ifdef DELAY_MUX_GLITCH_CNT_EN
  logic abort;
  assign abort = (state == CHK_HI && !s2) || (state == CHK_LO && s2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      glitch_cnt <= '0;
    else if (abort && glitch_cnt != {CNT_W{1'b1}})
      glitch_cnt <= glitch_cnt + 1'b1;
  end
`endif

endmodule
